// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Parametrised register file with NUM_RD combinational read ports and two
//   write ports. Write port B has priority over port A. A per-entry pending
//   scoreboard tells decode which entries still wait on an in-flight producer.
//   After reset, a sweep writes zero to every entry, one entry per cycle.
//   ready_o rises once the sweep has finished.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous reset, active-low
//   ready_o      1 = clearing sweep done, block operational
//   rd_addr_i    NUM_RD packed read addresses, port k at [k*AW +: AW]
//   rd_data_o    NUM_RD packed read data, port k at [k*DW +: DW]
//   rd_busy_o    per read port: the addressed entry is pending
//   wa_*         write port A (enable, address, data)
//   wb_*         write port B (enable, address, data), wins over port A
//   alloc_*      mark an entry pending when its producer issues
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 ready_o,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD*DW-1:0] rd_data_o,
    output logic [NUM_RD-1:0]    rd_busy_o,
    input  logic                 wa_en_i,
    input  logic [AW-1:0]        wa_addr_i,
    input  logic [DW-1:0]        wa_data_i,
    input  logic                 wb_en_i,
    input  logic [AW-1:0]        wb_addr_i,
    input  logic [DW-1:0]        wb_data_i,
    input  logic                 alloc_en_i,
    input  logic [AW-1:0]        alloc_addr_i
);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DW-1:0]     mem_q [DEPTH];

    // Memory write channels. Channel A also carries the sweep's zero writes.
    logic              a_we, b_we;
    logic [AW-1:0]     a_addr;
    logic [DW-1:0]     a_data;

    // Per-port scratch for the read loop
    logic [AW-1:0]     ra;
    logic              wa_hit, wb_hit;

    // Address 0 is a constant-zero entry when ZERO_REG is set.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign ready_o = (state_q == RUN);

    // Next state, sweep counter, scoreboard and write-channel selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        a_we    = 1'b0;
        a_addr  = wa_addr_i;
        a_data  = wa_data_i;
        b_we    = 1'b0;

        case (state_q)
            INIT: begin
                a_we   = rst_i;
                a_addr = cnt_q;
                a_data = '0;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                a_we = rst_i && wa_en_i && !is_zero(wa_addr_i);
                b_we = rst_i && wb_en_i && !is_zero(wb_addr_i);
                if (wa_en_i) pend_d[wa_addr_i] = 1'b0;
                if (wb_en_i) pend_d[wb_addr_i] = 1'b0;
                // Applied after the clears: a new producer outranks the retiring one.
                if (alloc_en_i && !is_zero(alloc_addr_i)) begin
                    pend_d[alloc_addr_i] = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // NOTE: the array has no reset; the INIT sweep clears it, so it maps onto plain RAM.
    // Port B is written last, so it wins when both ports hit the same entry.
    always_ff @(posedge clk_i) begin
        if (a_we) mem_q[a_addr]    <= a_data;
        if (b_we) mem_q[wb_addr_i] <= wb_data_i;
    end

    // Combinational read ports with same-cycle write bypass.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        ra        = '0;
        wa_hit    = 1'b0;
        wb_hit    = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra     = rd_addr_i[k*AW +: AW];
            wb_hit = wb_en_i && (wb_addr_i == ra);
            wa_hit = wa_en_i && (wa_addr_i == ra);
            if (state_q == RUN && !is_zero(ra)) begin
                if (wb_hit)      rd_data_o[k*DW +: DW] = wb_data_i;
                else if (wa_hit) rd_data_o[k*DW +: DW] = wa_data_i;
                else             rd_data_o[k*DW +: DW] = mem_q[ra];
                // Bypassed data is already valid, so never flag it busy.
                rd_busy_o[k] = pend_q[ra] && !(wa_hit || wb_hit);
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb
//   Bench for regfile_mp_sb. Instance u_dut uses the default parameters and
//   is checked with directed sequences, a vector table and random traffic
//   against a reference model. Instance u_var (DW=16, DEPTH=8, NUM_RD=4,
//   ZERO_REG=0) gets a short directed sequence.
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int DW = 32, DEPTH = 32, NUM_RD = 2, AW = 5;
    localparam int V_DW = 16, V_DEPTH = 8, V_NUM_RD = 4, V_AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic                 rst_n, ready;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic                 wa_en, wb_en, al_en;
    logic [AW-1:0]        wa_addr, wb_addr, al_addr;
    logic [DW-1:0]        wa_data, wb_data;

    regfile_mp_sb u_dut (
        .clk_i(clk), .rst_i(rst_n), .ready_o(ready),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .alloc_en_i(al_en), .alloc_addr_i(al_addr)
    );

    // Variant instance
    logic                     v_rst_n, v_ready;
    logic [V_NUM_RD*V_AW-1:0] v_rd_addr;
    logic [V_NUM_RD*V_DW-1:0] v_rd_data;
    logic [V_NUM_RD-1:0]      v_rd_busy;
    logic                     v_wa_en, v_wb_en, v_al_en;
    logic [V_AW-1:0]          v_wa_addr, v_wb_addr, v_al_addr;
    logic [V_DW-1:0]          v_wa_data, v_wb_data;

    regfile_mp_sb #(.DW(V_DW), .DEPTH(V_DEPTH), .NUM_RD(V_NUM_RD), .ZERO_REG(0)) u_var (
        .clk_i(clk), .rst_i(v_rst_n), .ready_o(v_ready),
        .rd_addr_i(v_rd_addr), .rd_data_o(v_rd_data), .rd_busy_o(v_rd_busy),
        .wa_en_i(v_wa_en), .wa_addr_i(v_wa_addr), .wa_data_i(v_wa_data),
        .wb_en_i(v_wb_en), .wb_addr_i(v_wb_addr), .wb_data_i(v_wb_data),
        .alloc_en_i(v_al_en), .alloc_addr_i(v_al_addr)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (default instance) ----------------
    // m_left = sweep cycles still to run; 0 means operational.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];
    int            m_left = DEPTH;

    task automatic model_edge();
        if (!rst_n) begin
            m_left = DEPTH;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (m_left > 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left--;
        end else begin
            if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
            if (wa_en) m_pend[wa_addr] = 1'b0;
            if (wb_en) m_pend[wb_addr] = 1'b0;
            if (al_en && al_addr != 0) m_pend[al_addr] = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (m_left > 0 || a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        if (wa_en && wa_addr == a) return wa_data;
        return m_mem[a];
    endfunction

    function automatic bit m_busy(input logic [AW-1:0] a);
        if (m_left > 0 || a == 0) return 1'b0;
        return m_pend[a] && !((wa_en && wa_addr == a) || (wb_en && wb_addr == a));
    endfunction

    task automatic check_model(input string tag);
        logic [AW-1:0] a;
        check({tag, ".ready"}, 64'(ready), 64'(m_left == 0));
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*AW +: AW];
            check($sformatf("%s.data%0d", tag, k), 64'(rd_data[k*DW +: DW]), 64'(m_rd(a)));
            check($sformatf("%s.busy%0d", tag, k), 64'(rd_busy[k]), 64'(m_busy(a)));
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+2.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; al_en = 0;
        wa_addr = '0; wb_addr = '0; al_addr = '0;
        wa_data = '0; wb_data = '0;
    endtask

    task automatic v_idle();
        v_wa_en = 0; v_wb_en = 0; v_al_en = 0;
        v_wa_addr = '0; v_wb_addr = '0; v_al_addr = '0;
        v_wa_data = '0; v_wb_data = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            wa_en;  logic [AW-1:0] wa_addr; logic [DW-1:0] wa_data;
        bit            wb_en;  logic [AW-1:0] wb_addr; logic [DW-1:0] wb_data;
        bit            al_en;  logic [AW-1:0] al_addr;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] ed0, ed1;
        logic [1:0]    eb;
    } vec_t;

    function automatic vec_t mk(bit we_a, int a_a, logic [31:0] d_a,
                                bit we_b, int a_b, logic [31:0] d_b,
                                bit al, int a_al, int r0, int r1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] b);
        vec_t v;
        v.wa_en = we_a; v.wa_addr = AW'(a_a); v.wa_data = d_a;
        v.wb_en = we_b; v.wb_addr = AW'(a_b); v.wb_data = d_b;
        v.al_en = al;   v.al_addr = AW'(a_al);
        v.ra0 = AW'(r0); v.ra1 = AW'(r1);
        v.ed0 = e0; v.ed1 = e1; v.eb = b;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        vecs[0]  = mk(1,  3, 32'hDEADBEEF, 0,  0, 0,            0,  0,  3,  4, 32'hDEADBEEF, 0,            2'b00);
        vecs[1]  = mk(0,  0, 0,            0,  0, 0,            0,  0,  3,  4, 32'hDEADBEEF, 0,            2'b00);
        vecs[2]  = mk(1,  9, 32'h11111111, 1,  9, 32'h22222222, 0,  0,  9,  3, 32'h22222222, 32'hDEADBEEF, 2'b00);
        vecs[3]  = mk(0,  0, 0,            0,  0, 0,            0,  0,  9,  0, 32'h22222222, 0,            2'b00);
        vecs[4]  = mk(1,  0, 32'hFFFFFFFF, 0,  0, 0,            0,  0,  0,  9, 0,            32'h22222222, 2'b00);
        vecs[5]  = mk(0,  0, 0,            0,  0, 0,            0,  0,  0,  0, 0,            0,            2'b00);
        vecs[6]  = mk(0,  0, 0,            0,  0, 0,            1, 12, 12, 12, 0,            0,            2'b00);
        vecs[7]  = mk(0,  0, 0,            0,  0, 0,            0,  0, 12,  9, 0,            32'h22222222, 2'b01);
        vecs[8]  = mk(0,  0, 0,            1, 12, 32'hABCD,     0,  0, 12, 12, 32'hABCD,     32'hABCD,     2'b00);
        vecs[9]  = mk(0,  0, 0,            0,  0, 0,            0,  0, 12, 12, 32'hABCD,     32'hABCD,     2'b00);
        vecs[10] = mk(1, 12, 32'h77,       0,  0, 0,            1, 12, 12,  5, 32'h77,       0,            2'b00);
        vecs[11] = mk(0,  0, 0,            0,  0, 0,            0,  0, 12, 12, 32'h77,       32'h77,       2'b11);
        vecs[12] = mk(0,  0, 0,            0,  0, 0,            1,  0,  0, 12, 0,            32'h77,       2'b10);
        vecs[13] = mk(0,  0, 0,            0,  0, 0,            0,  0,  0, 12, 0,            32'h77,       2'b10);
        vecs[14] = mk(1, 20, 32'hA,        1, 21, 32'hB,        0,  0, 20, 21, 32'hA,        32'hB,        2'b00);
        vecs[15] = mk(0,  0, 0,            0,  0, 0,            0,  0, 20, 21, 32'hA,        32'hB,        2'b00);
        vecs[16] = mk(1, 22, 32'hC,        1,  0, 32'hD,        0,  0,  0, 22, 0,            32'hC,        2'b00);
        vecs[17] = mk(0,  0, 0,            0,  0, 0,            0,  0, 22, 12, 32'hC,        32'h77,       2'b10);
        vecs[18] = mk(1, 12, 32'h99,       0,  0, 0,            0,  0, 20, 12, 32'hA,        32'h99,       2'b00);
        vecs[19] = mk(0,  0, 0,            0,  0, 0,            0,  0, 12, 12, 32'h99,       32'h99,       2'b00);
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; idle(); rd_addr = '0;
        v_rst_n = 1'b0; v_idle(); v_rd_addr = '0;
        @(posedge clk);
        #1;

        // Reset held 3 cycles, then the sweep; a write at sweep cycle 10 is ignored.
        repeat (3) step();
        rst_n = 1'b1;
        rd_addr = {AW'(31), AW'(5)};
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            if (i == 10) begin
                wa_en = 1; wa_addr = AW'(7); wa_data = 32'h12345678;
            end
            #1;
            check($sformatf("sweep%0d.ready", i), 64'(ready), 64'd0);
            check($sformatf("sweep%0d.data", i), 64'(rd_data), 64'd0);
            check($sformatf("sweep%0d.busy", i), 64'(rd_busy), 64'd0);
            step();
        end
        idle();
        rd_addr = {AW'(7), AW'(5)};
        #1;
        check("sweep_done.ready", 64'(ready), 64'd1);
        check("sweep_done.data", 64'(rd_data), 64'd0);
        rd_addr = {AW'(31), AW'(5)};
        #1;
        check("sweep_done.data31", 64'(rd_data), 64'd0);

        // Vector table
        for (int i = 0; i < $size(vecs); i++) begin
            wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            al_en = vecs[i].al_en; al_addr = vecs[i].al_addr;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check($sformatf("vec%0d.data0", i), 64'(rd_data[DW-1:0]), 64'(vecs[i].ed0));
            check($sformatf("vec%0d.data1", i), 64'(rd_data[2*DW-1:DW]), 64'(vecs[i].ed1));
            check($sformatf("vec%0d.busy", i), 64'(rd_busy), 64'(vecs[i].eb));
            check($sformatf("vec%0d.ready", i), 64'(ready), 64'd1);
            step();
        end

        // Reset mid-operation: pending on 2 and 5, entry 2 = 0x55
        idle(); wa_en = 1; wa_addr = AW'(2); wa_data = 32'h55; step();
        idle(); al_en = 1; al_addr = AW'(2); step();
        idle(); al_en = 1; al_addr = AW'(5); step();
        idle(); rd_addr = {AW'(5), AW'(2)};
        #1;
        check("midrst.pre_busy", 64'(rd_busy), 64'b11);
        check("midrst.pre_data", 64'(rd_data[DW-1:0]), 64'h55);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check($sformatf("midrst%0d.ready", i), 64'(ready), 64'd0);
            step();
        end
        #1;
        check("midrst.ready", 64'(ready), 64'd1);
        check("midrst.busy", 64'(rd_busy), 64'd0);
        check("midrst.data2", 64'(rd_data[DW-1:0]), 64'd0);

        // Random traffic against the model; addresses biased to a small range for collisions.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 249) != 0);
            wa_en   = $urandom_range(0, 1);
            wb_en   = $urandom_range(0, 1);
            al_en   = ($urandom_range(0, 2) == 0);
            wa_addr = AW'($urandom_range(0, 7));
            wb_addr = AW'($urandom_range(0, 7));
            al_addr = AW'($urandom_range(0, 7));
            wa_data = $urandom;
            wb_data = $urandom;
            for (int k = 0; k < NUM_RD; k++) begin
                rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            end
            #1;
            check_model($sformatf("rnd%0d", i));
            step();
        end
        rst_n = 1'b1; idle();

        // Variant instance: 8-cycle sweep, entry 0 is an ordinary entry
        repeat (2) step();
        v_rst_n = 1'b1;
        for (int i = 0; i < V_DEPTH; i++) begin
            #1;
            check($sformatf("v_sweep%0d.ready", i), 64'(v_ready), 64'd0);
            step();
        end
        #1;
        check("v_sweep_done.ready", 64'(v_ready), 64'd1);
        v_wa_en = 1; v_wa_addr = '0; v_wa_data = 16'h1234;
        #1;
        check("v_byp0", 64'(v_rd_data), {16'h0, {4{16'h1234}}} & 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        v_idle();
        #1;
        check("v_arr0", 64'(v_rd_data), {4{16'h1234}});
        check("v_arr0.busy", 64'(v_rd_busy), 64'd0);
        v_al_en = 1;
        step();
        v_idle();
        #1;
        check("v_alloc0.busy", 64'(v_rd_busy), 64'b1111);
        v_wa_en = 1; v_wa_addr = '0; v_wa_data = 16'h1111;
        v_wb_en = 1; v_wb_addr = '0; v_wb_data = 16'h5678;
        #1;
        check("v_coll0", 64'(v_rd_data), {4{16'h5678}});
        check("v_coll0.busy", 64'(v_rd_busy), 64'd0);
        step();
        v_idle();
        #1;
        check("v_coll0.stored", 64'(v_rd_data), {4{16'h5678}});
        check("v_coll0.cleared", 64'(v_rd_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
